// File: rtl/mem_write_arbiter.sv
// Per-lane write scheduler in front of mem_dualport: serializes same-address lanes in
// ascending lane order (last writer wins). Define MEM_ARB_COALESCE_EN to coalesce instead.

package GPU_Shader_pkg;
    localparam int unsigned lanes     = 4;
    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned WORD_W    = 32;
    typedef logic [WORD_W-1:0] word_t;
endpackage

module mem_write_arbiter #(
    parameter int unsigned LANES       = GPU_Shader_pkg::lanes,
    parameter int unsigned ADDR_WIDTH  = $clog2(GPU_Shader_pkg::MEM_DEPTH),
    parameter int unsigned STALL_CNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [LANES-1:0]              req_lane_en,
    input  logic [ADDR_WIDTH-1:0]         req_addr [LANES],
    input  GPU_Shader_pkg::word_t         req_data [LANES],
    output logic [LANES-1:0]              mem_write_en,
    output logic [ADDR_WIDTH-1:0]         mem_write_addr [LANES],
    output GPU_Shader_pkg::word_t         mem_write_data [LANES],
    output logic                          busy,
    output logic [STALL_CNT_W-1:0]        stall_count
);

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [LANES-1:0]        r_pending;
    logic [ADDR_WIDTH-1:0]   r_addr [LANES];
    GPU_Shader_pkg::word_t   r_data [LANES];
    logic [STALL_CNT_W-1:0]  r_stall;

    logic [LANES-1:0]        w_issue;
    logic [LANES-1:0]        w_retire;
    logic [LANES-1:0]        w_remain;
    logic                    w_ready;
    logic                    w_load;
    logic                    w_stall_inc;

    // Issue mask is a pure function of registered state, so mem_* never sees req_*.
    always_comb begin : issue_mask
        w_issue = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_issue[i] = r_pending[i];
`ifdef MEM_ARB_COALESCE_EN
            for (int j = i + 1; j < int'(LANES); j++) begin
                if (r_pending[j] && (r_addr[j] == r_addr[i])) w_issue[i] = 1'b0;
            end
`else
            for (int j = 0; j < i; j++) begin
                if (r_pending[j] && (r_addr[j] == r_addr[i])) w_issue[i] = 1'b0;
            end
`endif
        end
        if (r_state != S_ISSUE) w_issue = '0;
    end

    // Coalescing drops shadowed lanes, so every pending lane retires in one cycle.
    always_comb begin : retire_mask
`ifdef MEM_ARB_COALESCE_EN
        w_retire = (r_state == S_ISSUE) ? r_pending : '0;
`else
        w_retire = w_issue;
`endif
        w_remain = r_pending & ~w_retire;
    end

    always_ff @(posedge clk or negedge rst_n) begin : state_reg
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin : fsm_next
        w_state_next = r_state;
        w_ready      = 1'b0;
        w_load       = 1'b0;
        w_stall_inc  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (req_valid && (req_lane_en != '0)) begin
                    w_load       = 1'b1;
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_remain != '0) begin
                    w_stall_inc = 1'b1;
                end else begin
                    w_ready = 1'b1;
                    if (req_valid && (req_lane_en != '0)) w_load = 1'b1;
                    else                                  w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin : datapath
        if (!rst_n) begin
            r_pending <= '0;
            r_stall   <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            if (w_load) begin
                r_pending <= req_lane_en;
                for (int i = 0; i < int'(LANES); i++) begin
                    r_addr[i] <= req_addr[i];
                    r_data[i] <= req_data[i];
                end
            end else begin
                r_pending <= w_remain;
            end
            if (w_stall_inc && (r_stall != '1)) r_stall <= r_stall + STALL_CNT_W'(1);
        end
    end

    always_comb begin : outputs
        mem_write_en = w_issue;
        for (int i = 0; i < int'(LANES); i++) begin
            mem_write_addr[i] = r_addr[i];
            mem_write_data[i] = r_data[i];
        end
    end

    assign req_ready   = w_ready;
    assign busy        = (r_state == S_ISSUE);
    assign stall_count = r_stall;

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Scoreboard bench for mem_write_arbiter: expected issue cycles are queued at acceptance
// and a negedge monitor checks the DUT outputs against them.
`timescale 1ns/1ps
module tb_mem_write_arbiter;

    localparam int unsigned LANES = 4;
    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 256;

    typedef struct packed {
        logic [LANES-1:0]         en;
        logic [LANES-1:0][AW-1:0] addr;
        logic [LANES-1:0][DW-1:0] data;
    } issue_t;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready, req_ready2;
    logic [LANES-1:0]      req_lane_en;
    logic [AW-1:0]         req_addr [LANES];
    logic [DW-1:0]         req_data [LANES];
    logic [LANES-1:0]      mem_en, mem_en2;
    logic [AW-1:0]         mem_addr [LANES];
    logic [AW-1:0]         mem_addr2 [LANES];
    logic [DW-1:0]         mem_data [LANES];
    logic [DW-1:0]         mem_data2 [LANES];
    logic                  busy, busy2;
    logic [15:0]           stall16;
    logic [1:0]            stall2;

    mem_write_arbiter dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_lane_en(req_lane_en), .req_addr(req_addr), .req_data(req_data),
        .mem_write_en(mem_en), .mem_write_addr(mem_addr), .mem_write_data(mem_data),
        .busy(busy), .stall_count(stall16)
    );

    mem_write_arbiter #(.STALL_CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_lane_en(req_lane_en), .req_addr(req_addr), .req_data(req_data),
        .mem_write_en(mem_en2), .mem_write_addr(mem_addr2), .mem_write_data(mem_data2),
        .busy(busy2), .stall_count(stall2)
    );

    always #5 clk = ~clk;

    issue_t      q[$];
    int unsigned model_stall;
    logic [DW-1:0] sim_mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    int          checks   = 0;
    int          failures = 0;

    function automatic void check_eq(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: a lane's issue slot is its rank among same-address enabled lanes.
    function automatic void model_accept(logic [LANES-1:0] en,
                                         logic [LANES-1:0][AW-1:0] a,
                                         logic [LANES-1:0][DW-1:0] d);
        issue_t e;
        int     rank [LANES];
        int     k;
        if (en == '0) return;
        e.addr = a;
        e.data = d;
`ifdef MEM_ARB_COALESCE_EN
        e.en = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            logic keep;
            keep = en[i];
            for (int j = i + 1; j < int'(LANES); j++)
                if (en[j] && a[j] == a[i]) keep = 1'b0;
            e.en[i] = keep;
        end
        q.push_back(e);
        k = 1;
`else
        k = 0;
        for (int i = 0; i < int'(LANES); i++) begin
            rank[i] = 0;
            for (int j = 0; j < i; j++)
                if (en[i] && en[j] && a[j] == a[i]) rank[i]++;
            if (en[i] && rank[i] + 1 > k) k = rank[i] + 1;
        end
        for (int c = 0; c < k; c++) begin
            e.en = '0;
            for (int i = 0; i < int'(LANES); i++)
                if (en[i] && rank[i] == c) e.en[i] = 1'b1;
            q.push_back(e);
        end
`endif
        model_stall += k - 1;
        for (int i = 0; i < int'(LANES); i++)
            if (en[i]) ref_mem[a[i]] = d[i];
    endfunction

    // Monitor: compares outputs every cycle and plays the role of the memory.
    initial begin : monitor
        issue_t e;
        logic   ok;
        int unsigned e16, e2;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                e = '0;
                if (q.size() != 0) e = q[0];
                ok = (mem_en === e.en) && (mem_en2 === e.en);
                for (int i = 0; i < int'(LANES); i++)
                    if (e.en[i] && (mem_addr[i] !== e.addr[i] || mem_data[i] !== e.data[i]))
                        ok = 1'b0;
                checks++;
                if (!ok) begin
                    failures++;
                    $display("FAIL issue: en=%b addr0=%0d data0=%0d expected en=%b addr0=%0d data0=%0d at %0t",
                             mem_en, mem_addr[0], mem_data[0], e.en, e.addr[0], e.data[0], $time);
                end
                check_eq("busy", 32'(busy), 32'(q.size() != 0));
                check_eq("req_ready", 32'(req_ready), 32'(q.size() <= 1));
                if (q.size() == 0) begin
                    e16 = (model_stall > 65535) ? 65535 : model_stall;
                    e2  = (model_stall > 3) ? 3 : model_stall;
                    check_eq("stall_count", 32'(stall16), e16);
                    check_eq("stall_count_w2", 32'(stall2), e2);
                end
                for (int i = 0; i < int'(LANES); i++)
                    if (mem_en[i]) sim_mem[mem_addr[i]] = mem_data[i];
                if (q.size() != 0) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        int bad;
                        bad = 0;
                        for (int a = 0; a < int'(DEPTH); a++)
                            if (sim_mem[a] !== ref_mem[a]) bad++;
                        check_eq("mem_image_mismatches", 32'(bad), 32'd0);
                    end
                end
            end
        end
    end

    task automatic assert_reset();
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        q.delete();
        model_stall = 0;
        ref_mem     = sim_mem;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 assert_reset();
        @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic drive_batch(input logic v, input logic [LANES-1:0] en,
                               input logic [LANES-1:0][AW-1:0] a,
                               input logic [LANES-1:0][DW-1:0] d, output bit acc);
        @(negedge clk);
        req_valid   = v;
        req_lane_en = en;
        for (int i = 0; i < int'(LANES); i++) begin
            req_addr[i] = a[i];
            req_data[i] = d[i];
        end
        #1;
        acc = v && req_ready;
        if (acc) model_accept(en, a, d);
    endtask

    task automatic drive_until(input logic [LANES-1:0] en,
                               input logic [LANES-1:0][AW-1:0] a,
                               input logic [LANES-1:0][DW-1:0] d);
        bit acc;
        for (int t = 0; t < 50; t++) begin
            drive_batch(1'b1, en, a, d, acc);
            if (acc) return;
        end
        check_eq("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_wait();
        @(negedge clk);
        req_valid = 1'b0;
        for (int t = 0; t < 200; t++) begin
            #1;
            if (q.size() == 0) return;
            @(negedge clk);
        end
        check_eq("idle_timeout", 32'(q.size()), 32'd0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [LANES-1:0][AW-1:0] a;
        logic [LANES-1:0][DW-1:0] d;
        logic [LANES-1:0]         en;
        bit acc;
        int unsigned exp_s2, exp_s3, exp_m9r;

`ifdef MEM_ARB_COALESCE_EN
        exp_s2 = 0; exp_s3 = 0; exp_m9r = 4;
`else
        exp_s2 = 1; exp_s3 = 3; exp_m9r = 2;
`endif
        for (int i = 0; i < int'(DEPTH); i++) begin
            sim_mem[i] = '0;
            ref_mem[i] = '0;
        end
        model_stall = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_lane_en = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            req_addr[i] = '0;
            req_data[i] = '0;
        end
        #23 rst_n = 1'b1;
        #1;
        check_eq("reset_ready", 32'(req_ready), 32'd1);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_en", 32'(mem_en), 32'd0);
        check_eq("reset_stall", 32'(stall16), 32'd0);

        // 1: conflict-free full batch
        do_reset();
        for (int i = 0; i < 4; i++) begin a[i] = AW'(4 + i); d[i] = DW'(100 + i); end
        drive_until(4'b1111, a, d);
        idle_wait();
        for (int i = 0; i < 4; i++) check_eq("t1_mem", sim_mem[4 + i], 32'(100 + i));
        check_eq("t1_stall", 32'(stall16), 32'd0);

        // 2: two lanes collide on addr 5
        do_reset();
        a = '0; d = '0;
        a[0] = 8'd5; a[1] = 8'd5; d[0] = 32'd555; d[1] = 32'd999;
        drive_until(4'b0011, a, d);
        idle_wait();
        check_eq("t2_mem5", sim_mem[5], 32'd999);
        check_eq("t2_stall", 32'(stall16), exp_s2);

        // 3: four-deep collision on addr 9
        do_reset();
        for (int i = 0; i < 4; i++) begin a[i] = 8'd9; d[i] = DW'(i + 1); end
        drive_until(4'b1111, a, d);
        idle_wait();
        check_eq("t3_mem9", sim_mem[9], 32'd4);
        check_eq("t3_stall", 32'(stall16), exp_s3);

        // 4: back-to-back conflict-free batches
        do_reset();
        for (int i = 0; i < 4; i++) begin a[i] = AW'(20 + i); d[i] = DW'(200 + i); end
        drive_until(4'b1111, a, d);
        for (int i = 0; i < 4; i++) begin a[i] = AW'(24 + i); d[i] = DW'(300 + i); end
        drive_until(4'b1111, a, d);
        idle_wait();
        check_eq("t4_mem23", sim_mem[23], 32'd203);
        check_eq("t4_mem27", sim_mem[27], 32'd303);

        // 5: reset after the second issue cycle of the addr-9 collision
        do_reset();
        sim_mem[9] = '0;
        ref_mem[9] = '0;
        for (int i = 0; i < 4; i++) begin a[i] = 8'd9; d[i] = DW'(i + 1); end
        drive_until(4'b1111, a, d);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 assert_reset();
        #1;
        check_eq("t5_en_in_reset", 32'(mem_en), 32'd0);
        check_eq("t5_busy_in_reset", 32'(busy), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1;
        check_eq("t5_ready", 32'(req_ready), 32'd1);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_stall", 32'(stall16), 32'd0);
        check_eq("t5_mem9", sim_mem[9], exp_m9r);
        ref_mem = sim_mem;

        // 6: counter saturation on the 2-bit instance
        do_reset();
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) begin a[i] = 8'd3; d[i] = $urandom; end
            drive_until(4'b1111, a, d);
        end
        idle_wait();
        check_eq("t6_stall_w2", 32'(stall2), 32'(exp_s3 * 3 > 3 ? 3 : exp_s3 * 3));
        check_eq("t6_stall_w16", 32'(stall16), 32'(exp_s3 * 3));

        // Random batches, narrow address range to provoke collisions
        do_reset();
        for (int n = 0; n < 400; n++) begin
            int unsigned span;
            span = ($urandom_range(0, 3) == 0) ? 255 : 3;
            en = LANES'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) begin
                a[i] = AW'($urandom_range(0, span));
                d[i] = $urandom;
            end
            drive_batch(($urandom_range(0, 4) != 0), en, a, d, acc);
        end
        idle_wait();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
